// File: rtl/clk_gen_pkg.sv
// -----------------------------------------------------------------------------
// clk_gen_pkg
// Shared types and helpers for the ring-oscillator frequency meter.
//   - meter_state_e : measurement FSM states
//   - DEF_*         : default widths / depths used as parameter defaults
//   - sat_inc       : saturating increment (operands up to 32 bits wide)
// -----------------------------------------------------------------------------
package clk_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    COUNT  = 2'd2,
    DONE   = 2'd3
  } meter_state_e;

  localparam int unsigned DEF_CNT_WIDTH     = 16;
  localparam int unsigned DEF_WIN_WIDTH     = 16;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_SETTLE_CYCLES = 4;

  // Returns val+1, or max_val once val has reached max_val.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val);
    logic [31:0] res;
    if (val >= max_val) begin
      res = max_val;
    end else begin
      res = val + 32'd1;
    end
    return res;
  endfunction

endpackage

// File: rtl/clk_gen_sync_edge.sv
// -----------------------------------------------------------------------------
// clk_gen_sync_edge
// Brings the asynchronous divided oscillator into the core clock domain and
// detects its rising edges.
// Ports:
//   clk_i, reset_i : core clock, synchronous active-high reset
//   osc_i          : asynchronous oscillator input
//   prime_i        : load the history flop with the synced level (no count)
//   en_i           : counting window active; history tracks and rises report
//   synced_o       : synchronized oscillator level
//   rise_o         : one-cycle pulse on a synced 0->1 transition while en_i
// -----------------------------------------------------------------------------
module clk_gen_sync_edge
  import clk_gen_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic osc_i,
  input  logic prime_i,
  input  logic en_i,
  output logic synced_o,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_d, sync_q;
  logic                   hist_d, hist_q;

  // Synchronizer shift and history update; history only moves while priming
  // or counting so that a level present at window start is never an edge.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], osc_i};
    if (prime_i || en_i) begin
      hist_d = sync_q[SYNC_STAGES-1];
    end else begin
      hist_d = hist_q;
    end
  end

  // Synchronizer and history flops.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync_q <= {SYNC_STAGES{1'b0}};
      hist_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  // Level and rise outputs derive only from the synchronized stage.
  always_comb begin
    synced_o = sync_q[SYNC_STAGES-1];
    rise_o   = en_i & sync_q[SYNC_STAGES-1] & ~hist_q;
  end

endmodule

// File: rtl/clk_gen_freq_meter.sv
// -----------------------------------------------------------------------------
// clk_gen_freq_meter
// Counts rising edges of the (divided) ring-oscillator output over a
// programmable window of core cycles and returns the result through a
// valid/yumi handshake.
//
// Optional feature macro: CLK_GEN_FREQ_METER_LIMIT_CHECK_EN
//   When defined, adds lo_i/hi_i limit inputs and the in_range_o flag.
//
// Ports:
//   clk_i, reset_i : core clock, synchronous active-high reset
//   osc_i          : divided oscillator, asynchronous, below clk_i/2
//   start_i        : measurement request (accepted in IDLE only)
//   win_cycles_i   : window length in core cycles, latched at acceptance
//   busy_o         : measurement in SETTLE, COUNT or DONE
//   v_o            : result valid
//   count_o        : rising edges counted (saturating)
//   overflow_o     : count saturated (sticky for this measurement)
//   yumi_i         : consumer takes the result while v_o=1
//   lo_i, hi_i     : (option) inclusive limits for in_range_o
//   in_range_o     : (option) result within limits and not overflowed
// -----------------------------------------------------------------------------
module clk_gen_freq_meter
  import clk_gen_pkg::*;
#(
  parameter int unsigned CNT_WIDTH     = DEF_CNT_WIDTH,
  parameter int unsigned WIN_WIDTH     = DEF_WIN_WIDTH,
  parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 osc_i,
  input  logic                 start_i,
  input  logic [WIN_WIDTH-1:0] win_cycles_i,
  output logic                 busy_o,
  output logic                 v_o,
  output logic [CNT_WIDTH-1:0] count_o,
  output logic                 overflow_o,
  input  logic                 yumi_i
`ifdef CLK_GEN_FREQ_METER_LIMIT_CHECK_EN
  ,
  input  logic [CNT_WIDTH-1:0] lo_i,
  input  logic [CNT_WIDTH-1:0] hi_i,
  output logic                 in_range_o
`endif
);

  localparam int unsigned          SET_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SET_W-1:0]     SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SET_W-1:0]     SET_ZERO    = {SET_W{1'b0}};
  localparam logic [SET_W-1:0]     SET_ONE     = {{(SET_W-1){1'b0}}, 1'b1};
  localparam logic [WIN_WIDTH-1:0] WIN_ZERO    = {WIN_WIDTH{1'b0}};
  localparam logic [WIN_WIDTH-1:0] WIN_ONE     = {{(WIN_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO    = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_MAX     = {CNT_WIDTH{1'b1}};

  meter_state_e         state_d, state_q;
  logic [SET_W-1:0]     settle_d, settle_q;   // remaining SETTLE cycles - 1
  logic [WIN_WIDTH-1:0] win_d, win_q;         // remaining COUNT cycles
  logic [CNT_WIDTH-1:0] count_d, count_q;
  logic                 ovf_d, ovf_q;
  logic                 busy_d, busy_q;
  logic                 v_d, v_q;
  logic                 prime_s, en_s;
  logic                 synced_s, rise_s;
  logic                 sync_unused_s;

  clk_gen_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .osc_i   (osc_i),
    .prime_i (prime_s),
    .en_i    (en_s),
    .synced_o(synced_s),
    .rise_o  (rise_s)
  );

  // The synced level is kept as a debug observation point only.
  assign sync_unused_s = synced_s;

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic. A zero window skips COUNT entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q != SET_ZERO) begin
          state_d = SETTLE;
        end else if (win_q == WIN_ZERO) begin
          state_d = DONE;
        end else begin
          state_d = COUNT;
        end
      end
      COUNT: begin
        if (win_q == WIN_ONE) begin
          state_d = DONE;
        end else begin
          state_d = COUNT;
        end
      end
      DONE: begin
        if (yumi_i) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM output decode: edge-detector control from the current state, and
  // registered handshake outputs from the next state.
  always_comb begin
    prime_s = (state_q == SETTLE);
    en_s    = (state_q == COUNT);
    busy_d  = (state_d != IDLE);
    v_d     = (state_d == DONE);
  end

  // Datapath next values: window/settle timers, saturating count, overflow.
  always_comb begin
    settle_d = settle_q;
    win_d    = win_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          win_d    = win_cycles_i;
          settle_d = SETTLE_LOAD;
        end else begin
          win_d    = win_q;
          settle_d = settle_q;
        end
      end
      SETTLE: begin
        count_d = CNT_ZERO;
        ovf_d   = 1'b0;
        if (settle_q != SET_ZERO) begin
          settle_d = settle_q - SET_ONE;
        end else begin
          settle_d = settle_q;
        end
      end
      COUNT: begin
        win_d = win_q - WIN_ONE;
        if (rise_s) begin
          // An edge arriving when already saturated marks the overflow.
          if (count_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            ovf_d = ovf_q;
          end
          count_d = CNT_WIDTH'(sat_inc(32'(count_q), 32'(CNT_MAX)));
        end else begin
          count_d = count_q;
          ovf_d   = ovf_q;
        end
      end
      DONE: begin
        count_d = count_q;
        ovf_d   = ovf_q;
      end
      default: begin
        count_d = count_q;
        ovf_d   = ovf_q;
      end
    endcase
  end

  // Datapath and output registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      settle_q <= SET_ZERO;
      win_q    <= WIN_ZERO;
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
      busy_q   <= 1'b0;
      v_q      <= 1'b0;
    end else begin
      settle_q <= settle_d;
      win_q    <= win_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      busy_q   <= busy_d;
      v_q      <= v_d;
    end
  end

  assign busy_o     = busy_q;
  assign v_o        = v_q;
  assign count_o    = count_q;
  assign overflow_o = ovf_q;

`ifdef CLK_GEN_FREQ_METER_LIMIT_CHECK_EN
  logic in_range_d, in_range_q;

  // Limit compare, evaluated on the value that will be presented in DONE;
  // lo_i/hi_i are expected to be stable before the result becomes valid.
  always_comb begin
    if (state_d == DONE) begin
      in_range_d = (count_d >= lo_i) && (count_d <= hi_i) && !ovf_d;
    end else begin
      in_range_d = 1'b0;
    end
  end

  // In-range flag register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      in_range_q <= 1'b0;
    end else begin
      in_range_q <= in_range_d;
    end
  end

  assign in_range_o = in_range_q;
`endif

endmodule
